// File: rtl/fetch_pc_if.sv
// Instruction-memory fetch channel between the fetch stage and instruction memory.
// The fetch stage holds req/addr until memory answers with ack/rdata.
interface fetch_pc_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_pc.sv
// MIPS instruction-fetch stage: owns the PC, fetches over a req/ack channel and
// holds the instruction until the datapath advances, then steps to the next PC.
//
// state   | meaning
// S_IDLE  | one cycle after reset, no request yet
// S_FETCH | request outstanding at pc, waiting for imem_ack
// S_VALID | instr holds a fetched word, waiting for advance
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_pc_if.master  imem,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [31:0] branch_offset
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_t      state, state_nxt;
  logic [31:0] next_pc;
  logic        capture;
  logic        step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (imem.imem_ack) state_nxt = S_VALID;
      S_VALID: if (advance) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req  = (state == S_FETCH);
    imem.imem_addr = pc;
    instr_valid    = (state == S_VALID);
  end

  assign capture  = (state == S_FETCH) && imem.imem_ack;
  assign step     = (state == S_VALID) && advance;
  assign pc_plus4 = pc + 32'd4;
  assign opcode   = instr[31:26];

  // jump wins outright; branch/zero may be garbage whenever jump is set
  always_comb begin
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + (branch_offset << 2);
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= PC_INIT;
      instr <= 32'h0000_0000;
    end else begin
      if (capture) instr <= imem.imem_rdata;
      if (step)    pc    <= {next_pc[31:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: stimulus pushes the expected (pc, instr) of every
// acknowledged fetch; a monitor pops and compares when instr_valid rises.
module tb_fetch_pc;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] branch_offset = 32'h0;

  int total = 0;
  int bad = 0;
  logic [63:0] sb[$];
  logic        prev_valid = 1'b0;
  logic [31:0] last_word = 32'h0;

  fetch_pc_if mif ();

  fetch_pc #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (mif),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .advance       (advance),
    .branch        (branch),
    .zero          (zero),
    .jump          (jump),
    .branch_offset (branch_offset)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      prev_valid <= instr_valid;
      if (instr_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_valid", 32'd1, 32'd0);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          check("mon_pc", pc, e[63:32]);
          check("mon_instr", instr, e[31:0]);
          check("mon_opcode", {26'd0, opcode}, {26'd0, e[31:26]});
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] w, input int waits,
                       input logic stray_adv);
    int n;
    n = 0;
    while (mif.imem_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_seen", {31'd0, mif.imem_req}, 32'd1);
    check("fetch_addr", mif.imem_addr, a);
    for (int i = 0; i < waits; i++) begin
      advance = stray_adv;
      @(posedge clk); #1;
      advance = 1'b0;
      check("wait_req", {31'd0, mif.imem_req}, 32'd1);
      check("wait_addr", mif.imem_addr, a);
      check("wait_pc", pc, a);
      check("wait_instr", instr, last_word);
    end
    mif.imem_ack = 1'b1;
    mif.imem_rdata = w;
    sb.push_back({a, w});
    @(posedge clk); #1;
    mif.imem_ack = 1'b0;
    mif.imem_rdata = 32'h0;
    last_word = w;
    check("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    check("req_drop", {31'd0, mif.imem_req}, 32'd0);
  endtask

  task automatic adv(input logic b, input logic z, input logic j,
                     input logic [31:0] off, input logic [31:0] exp_pc);
    check("adv_valid", {31'd0, instr_valid}, 32'd1);
    branch = b; zero = z; jump = j; branch_offset = off;
    advance = 1'b1;
    @(posedge clk); #1;
    advance = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0; branch_offset = 32'h0;
    check("next_pc", pc, exp_pc);
    check("next_addr", mif.imem_addr, exp_pc);
    check("next_req", {31'd0, mif.imem_req}, 32'd1);
    check("next_notvalid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    mif.imem_ack = 1'b0;
    mif.imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_instr", instr, 32'h0);
    check("rst_opcode", {26'd0, opcode}, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_req", {31'd0, mif.imem_req}, 32'd0);
    check("rst_addr", mif.imem_addr, RST_PC);
    rst_n = 1'b1;
    check("idle_req", {31'd0, mif.imem_req}, 32'd0);
    @(posedge clk); #1;
    check("first_req", {31'd0, mif.imem_req}, 32'd1);
    check("first_addr", mif.imem_addr, RST_PC);

    // sequential zero-wait stream, then jump into low memory
    fetch(32'h0040_0000, 32'h2001_0001, 0, 1'b0);
    check("pc_plus4", pc_plus4, 32'h0040_0004);
    adv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0004);
    fetch(32'h0040_0004, 32'h2002_0002, 0, 1'b0);
    adv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0008);
    fetch(32'h0040_0008, 32'h0800_0040, 0, 1'b0);
    adv(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0100);

    // branch taken backwards, then not taken
    fetch(32'h0000_0100, 32'h1000_FFFE, 0, 1'b0);
    adv(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_00FC);
    fetch(32'h0000_00FC, 32'h1000_0005, 0, 1'b0);
    adv(1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0100);
    fetch(32'h0000_0100, 32'h1000_FFFE, 0, 1'b0);
    adv(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0104);

    // wait states with stray advance, then stray ack while valid
    fetch(32'h0000_0104, 32'h1000_0123, 3, 1'b1);
    mif.imem_ack = 1'b1;
    mif.imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mif.imem_ack = 1'b0;
    mif.imem_rdata = 32'h0;
    check("stray_ack_instr", instr, 32'h1000_0123);
    check("stray_ack_valid", {31'd0, instr_valid}, 32'd1);
    check("stray_ack_pc", pc, 32'h0000_0104);
    adv(1'b1, 1'b1, 1'b0, 32'h03FF_FFBE, 32'h1000_0000);

    // jump overrides a taken branch
    fetch(32'h1000_0000, 32'h0800_0040, 0, 1'b0);
    adv(1'b1, 1'b1, 1'b1, 32'h0000_0007, 32'h1000_0100);

    // climb to the top of the address space and wrap
    fetch(32'h1000_0100, 32'h1000_0001, 0, 1'b0);
    adv(1'b1, 1'b1, 1'b0, 32'h3BFF_FFBE, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 1, 1'b0);
    check("wrap_plus4", pc_plus4, 32'h0000_0000);
    adv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000);

    // reset lands in the same cycle as an ack
    mif.imem_ack = 1'b1;
    mif.imem_rdata = 32'hCAFE_F00D;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc, RST_PC);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_req", {31'd0, mif.imem_req}, 32'd0);
    @(posedge clk); #1;
    mif.imem_ack = 1'b0;
    mif.imem_rdata = 32'h0;
    check("held_rst_instr", instr, 32'h0);
    check("held_rst_valid", {31'd0, instr_valid}, 32'd0);
    rst_n = 1'b1;
    last_word = 32'h0;
    check("re_idle_req", {31'd0, mif.imem_req}, 32'd0);
    @(posedge clk); #1;
    fetch(RST_PC, 32'h2003_0003, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
